// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Brief    : Shared constants, write-request record and FSM states for the
//            framebuffer SRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int SCREEN_W = 400;
    localparam int SCREEN_H = 300;
    localparam int COLOR_W  = 6;
    localparam int COORD_W  = 9;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } fb_wr_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    // Zero-extends a pixel colour onto the 16-bit SRAM data bus.
    function automatic logic [15:0] fb_color_to_word(input logic [COLOR_W-1:0] color);
        return {{(16-COLOR_W){1'b0}}, color};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fb_wr_fifo
// Brief    : Synchronous FIFO of pixel writes with registered full/empty flags.
// Revision : 1.0 - initial release
// ============================================================================
module fb_wr_fifo #(
    parameter int DEPTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  fb_pkg::fb_wr_t data_i,
    input  logic           pop_i,
    output fb_pkg::fb_wr_t head_o,
    output logic           full_o,
    output logic           empty_o
);
    import fb_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fb_wr_t        mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/fb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_sram_arbiter
// Brief    : Shares the framebuffer SRAM port between VGA reads (priority),
//            queued game-logic writes and a screen-clear engine.
//            Optional macro ARB_STATS_EN enables the writer stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module fb_sram_arbiter #(
    parameter int SCREEN_W = fb_pkg::SCREEN_W,
    parameter int SCREEN_H = fb_pkg::SCREEN_H,
    parameter int WQ_DEPTH = 8
) (
    input  logic                       clk50M,
    input  logic                       rst,
    input  logic                       disp_active,
    input  logic [8:0]                 disp_x,
    input  logic [8:0]                 disp_y,
    input  logic                       wr_req,
    input  logic [8:0]                 wr_x,
    input  logic [8:0]                 wr_y,
    input  logic [fb_pkg::COLOR_W-1:0] wr_data,
    output logic                       wr_ready,
    input  logic                       clear_start,
    input  logic [fb_pkg::COLOR_W-1:0] clear_color,
    output logic                       clear_busy,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [8:0]                 mem_x,
    output logic [8:0]                 mem_y,
    output logic [15:0]                mem_wdata,
    output logic [15:0]                stall_cycles
);
    import fb_pkg::*;

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(SCREEN_H - 1);

    fb_state_e          state_q;
    logic [COORD_W-1:0] cx_q, cy_q;
    logic [COLOR_W-1:0] color_q;
    logic               busy_q;

    fb_wr_t fifo_in, fifo_head;
    logic   fifo_full, fifo_empty, fifo_push, fifo_pop, in_range;

    assign in_range  = (wr_x <= LAST_X) && (wr_y <= LAST_Y);
    assign wr_ready  = !rst && !fifo_full;
    // Out-of-range pixels complete the handshake but are never stored.
    assign fifo_push = wr_req && wr_ready && in_range;
    assign fifo_pop  = !rst && !disp_active && (state_q == IDLE) && !fifo_empty;
    assign fifo_in   = '{x: wr_x, y: wr_y, color: wr_data};

    fb_wr_fifo #(
        .DEPTH (WQ_DEPTH)
    ) u_fifo (
        .clk_i   (clk50M),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_x     = '0;
        mem_y     = '0;
        mem_wdata = '0;
        if (disp_active) begin
            mem_read = 1'b1;
            mem_x    = disp_x;
            mem_y    = disp_y;
        end else if (!rst) begin
            if (state_q == CLEAR) begin
                mem_write = 1'b1;
                mem_x     = cx_q;
                mem_y     = cy_q;
                mem_wdata = fb_color_to_word(color_q);
            end else if (!fifo_empty) begin
                mem_write = 1'b1;
                mem_x     = fifo_head.x;
                mem_y     = fifo_head.y;
                mem_wdata = fb_color_to_word(fifo_head.color);
            end
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        state_q <= CLEAR;
                        cx_q    <= '0;
                        cy_q    <= '0;
                        color_q <= clear_color;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // The raster only advances on cycles the display leaves free.
                    if (!disp_active) begin
                        if (cx_q == LAST_X) begin
                            cx_q <= '0;
                            if (cy_q == LAST_Y) begin
                                cy_q    <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                cy_q <= cy_q + 1'b1;
                            end
                        end else begin
                            cx_q <= cx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clear_busy = busy_q;

`ifdef ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            stall_q <= '0;
        end else if (wr_req && !wr_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_sram_arbiter
// Brief    : Directed self-checking bench for fb_sram_arbiter (small screen).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_sram_arbiter;

    localparam int W = 10;
    localparam int H = 4;
`ifdef ARB_STATS_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        clk50M = 1'b0;
    logic        rst, disp_active, wr_req, clear_start;
    logic [8:0]  disp_x, disp_y, wr_x, wr_y;
    logic [5:0]  wr_data, clear_color;
    logic        wr_ready, clear_busy, mem_read, mem_write;
    logic [8:0]  mem_x, mem_y;
    logic [15:0] mem_wdata, stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk50M = ~clk50M;

    fb_sram_arbiter #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .WQ_DEPTH (8)
    ) dut (
        .clk50M       (clk50M),
        .rst          (rst),
        .disp_active  (disp_active),
        .disp_x       (disp_x),
        .disp_y       (disp_y),
        .wr_req       (wr_req),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .clear_start  (clear_start),
        .clear_color  (clear_color),
        .clear_busy   (clear_busy),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_x        (mem_x),
        .mem_y        (mem_y),
        .mem_wdata    (mem_wdata),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks land mid-cycle.
    task automatic next();
        @(posedge clk50M);
        #1;
    endtask

    task automatic expect_write(input string tag, input int x, input int y, input int c);
        chk({tag, "_we"}, 32'(mem_write), 1);
        chk({tag, "_re"}, 32'(mem_read), 0);
        chk({tag, "_x"}, 32'(mem_x), 32'(x));
        chk({tag, "_y"}, 32'(mem_y), 32'(y));
        chk({tag, "_d"}, 32'(mem_wdata), 32'(c));
    endtask

    task automatic set_push(input int x, input int y, input int c);
        wr_req  = 1'b1;
        wr_x    = 9'(x);
        wr_y    = 9'(y);
        wr_data = 6'(c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  ex, ey;
        bit  done;

        rst = 1'b1; disp_active = 1'b1; disp_x = 9'd3; disp_y = 9'd4;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        clear_start = 1'b0; clear_color = '0;
        next(); next();
        #5;
        chk("rst_read", 32'(mem_read), 1);
        chk("rst_ready", 32'(wr_ready), 0);
        chk("rst_write", 32'(mem_write), 0);
        chk("rst_x", 32'(mem_x), 3);
        next();
        rst = 1'b0; disp_active = 1'b0;
        #5;
        chk("post_rst_busy", 32'(clear_busy), 0);
        chk("post_rst_stall", 32'(stall_cycles), 0);
        chk("post_rst_ready", 32'(wr_ready), 1);
        chk("idle_write", 32'(mem_write), 0);
        chk("idle_read", 32'(mem_read), 0);
        next();

        // Display owns the port while three pixels queue up behind it.
        disp_active = 1'b1; disp_x = 9'd17; disp_y = 9'd42;
        for (int i = 0; i < 3; i++) begin
            set_push(1 + 2*i, i, 10 + i);
            #5;
            chk("t1_read", 32'(mem_read), 1);
            chk("t1_write", 32'(mem_write), 0);
            chk("t1_x", 32'(mem_x), 17);
            chk("t1_y", 32'(mem_y), 42);
            next();
        end
        wr_req = 1'b0; disp_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #5; expect_write("t1_drain", 1 + 2*i, i, 10 + i);
            next();
        end
        #5; chk("t1_empty", 32'(mem_write), 0);
        next();

        // No fall-through: a push into an empty FIFO is written a cycle later.
        set_push(5, 6 % H, 6'h3F);
        #5; chk("t2_nofall", 32'(mem_write), 0);
        next();
        set_push(7, 8 % H, 6'h01);
        #5; expect_write("t2_a", 5, 6 % H, 16'h003F);
        next();
        wr_req = 1'b0;
        #5; expect_write("t2_b", 7, 8 % H, 16'h0001);
        next();
        #5; chk("t2_empty", 32'(mem_write), 0);
        next();

        // Fill to full under display, stall five cycles, then drain.
        disp_active = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_push(i, i % H, i + 8);
            #5; chk("t3_ready", 32'(wr_ready), 1);
            next();
        end
        set_push(9, 0, 6'h3E);
        for (int i = 0; i < 5; i++) begin
            #5; chk("t3_full", 32'(wr_ready), 0);
            next();
        end
        wr_req = 1'b0;
        #5; chk("t3_stall", 32'(stall_cycles), STALL_EXP);
        next();
        disp_active = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #5;
            expect_write("t3_drain", i, i % H, i + 8);
            chk("t3_ready_drain", 32'(wr_ready), (i == 0) ? 0 : 1);
            next();
        end
        #5; chk("t3_empty", 32'(mem_write), 0);
        next();

        // Out-of-range pushes complete the handshake but are never written.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_push(400, 10, 1);
                1: set_push(3, 300, 2);
                2: set_push(W, 1, 3);
                default: set_push(3, H, 4);
            endcase
            #5;
            chk("t4_ready", 32'(wr_ready), 1);
            chk("t4_write", 32'(mem_write), 0);
            next();
        end
        wr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #5; chk("t4_nowrite", 32'(mem_write), 0);
            next();
        end

        // Full-screen clear with display interruptions and a mid-clear push.
        clear_start = 1'b1; clear_color = 6'h2A;
        #5;
        chk("t5_start_write", 32'(mem_write), 0);
        chk("t5_start_busy", 32'(clear_busy), 0);
        next();
        ex = 0; ey = 0; done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            disp_active = (n % 7 == 3);
            clear_start = (n == 8);
            clear_color = (n == 8) ? 6'h01 : 6'h2A;
            if (n == 5) set_push(9, 3, 6'h15);
            else wr_req = 1'b0;
            #5;
            chk("t5_busy", 32'(clear_busy), 1);
            if (n == 5) chk("t5_push_ready", 32'(wr_ready), 1);
            if (disp_active) begin
                chk("t5_disp_read", 32'(mem_read), 1);
                chk("t5_disp_write", 32'(mem_write), 0);
                chk("t5_disp_x", 32'(mem_x), 17);
            end else begin
                expect_write("t5_clr", ex, ey, 16'h002A);
                if (ex == W - 1) begin
                    ex = 0;
                    if (ey == H - 1) done = 1'b1;
                    else ey++;
                end else begin
                    ex++;
                end
            end
            next();
        end
        disp_active = 1'b0; clear_start = 1'b0; wr_req = 1'b0;
        if (!done) chk("t5_clear_timeout", 0, 1);
        #5;
        chk("t5_busy_fall", 32'(clear_busy), 0);
        expect_write("t5_after", 9, 3, 16'h0015);
        next();
        #5; chk("t5_idle", 32'(mem_write), 0);
        next();

        // Reset midway through a clear with four queued writes.
        clear_start = 1'b1; clear_color = 6'h11;
        #5; next();
        clear_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #5; expect_write("t6_clr", k, 0, 16'h0011);
            next();
        end
        disp_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_push(i, 1, i + 1);
            #5; chk("t6_ready", 32'(wr_ready), 1);
            next();
        end
        wr_req = 1'b0; disp_active = 1'b0; rst = 1'b1;
        #5;
        chk("t6_rst_write", 32'(mem_write), 0);
        chk("t6_rst_read", 32'(mem_read), 0);
        chk("t6_rst_ready", 32'(wr_ready), 0);
        next();
        rst = 1'b0;
        #5;
        chk("t6_busy", 32'(clear_busy), 0);
        chk("t6_ready_after", 32'(wr_ready), 1);
        chk("t6_stall", 32'(stall_cycles), 0);
        next();
        for (int i = 0; i < 4; i++) begin
            #5; chk("t6_nowrite", 32'(mem_write), 0);
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
